// File: rtl/retire_perf_counters_pkg.sv
// Shared constants for the retire performance-counter unit: counter indices,
// counter count and default counter width.
package retire_perf_counters_pkg;

  localparam int PERF_CNT_W_DEFAULT = 32;
  localparam int PERF_NUM_CNT       = 6;

  localparam logic [2:0] PERF_IDX_CYCLE = 3'd0;
  localparam logic [2:0] PERF_IDX_INST  = 3'd1;
  localparam logic [2:0] PERF_IDX_IREQ  = 3'd2;
  localparam logic [2:0] PERF_IDX_IHIT  = 3'd3;
  localparam logic [2:0] PERF_IDX_DREQ  = 3'd4;
  localparam logic [2:0] PERF_IDX_DHIT  = 3'd5;

endpackage

// File: rtl/retire_perf_counters_perf_counter.sv
// One performance counter with clear, freeze and increment. Wraps by default;
// saturates at all-ones when PERF_SATURATE_EN is defined.
module perf_counter
  import retire_perf_counters_pkg::*;
#(
  parameter int CNT_W = PERF_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             freeze,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  logic [CNT_W-1:0] count_q, count_d;

  // clr wins over any increment and also lifts the freeze
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (!freeze && inc) begin
`ifdef PERF_SATURATE_EN
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
`else
      count_d = count_q + 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

`ifdef PERF_SATURATE_EN
  assign sat = &count_q;
`else
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/retire_perf_counters.sv
// Retire-side performance counters with halt freeze, sticky error flag and a
// registered read port. Optional saturation via PERF_SATURATE_EN.
module retire_perf_counters
  import retire_perf_counters_pkg::*;
#(
  parameter int CNT_W = PERF_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             reg_write,
  input  logic             mem_write,
  input  logic             icache_req,
  input  logic             icache_hit,
  input  logic             dcache_req,
  input  logic             dcache_hit,
  input  logic             clr,
  input  logic [2:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             halted,
  output logic             halt_pulse,
  output logic             hit_err
);

  logic [PERF_NUM_CNT-1:0] inc;
  logic [PERF_NUM_CNT-1:0] sat;
  logic [CNT_W-1:0]        cnt [8];

  logic             halted_q, halted_d;
  logic             halt_pulse_q, halt_pulse_d;
  logic             hit_err_q, hit_err_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  // Retire of any kind counts as a single instruction per cycle
  assign inc[PERF_IDX_CYCLE] = 1'b1;
  assign inc[PERF_IDX_INST]  = halt | reg_write | mem_write;
  assign inc[PERF_IDX_IREQ]  = icache_req;
  assign inc[PERF_IDX_IHIT]  = icache_hit & icache_req;
  assign inc[PERF_IDX_DREQ]  = dcache_req;
  assign inc[PERF_IDX_DHIT]  = dcache_hit & dcache_req;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_cnt
      if (gi < PERF_NUM_CNT) begin : g_real
        perf_counter #(.CNT_W(CNT_W)) u_cnt (
          .clk    (clk),
          .rst    (rst),
          .clr    (clr),
          .freeze (halted_q),
          .inc    (inc[gi]),
          .count  (cnt[gi]),
          .sat    (sat[gi])
        );
      end else begin : g_zero
        assign cnt[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    halted_d     = halted_q;
    halt_pulse_d = 1'b0;
    hit_err_d    = hit_err_q;
    rd_data_d    = cnt[rd_sel];
    if (clr) begin
      halted_d  = 1'b0;
      hit_err_d = 1'b0;
    end else if (!halted_q) begin
      if (halt) begin
        halted_d     = 1'b1;
        halt_pulse_d = 1'b1;
      end
      if ((icache_hit & ~icache_req) | (dcache_hit & ~dcache_req) | (|sat))
        hit_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      halted_q     <= 1'b0;
      halt_pulse_q <= 1'b0;
      hit_err_q    <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      halted_q     <= halted_d;
      halt_pulse_q <= halt_pulse_d;
      hit_err_q    <= hit_err_d;
      rd_data_q    <= rd_data_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign halted     = halted_q;
  assign halt_pulse = halt_pulse_q;
  assign hit_err    = hit_err_q;

endmodule
